friscv_inst_queue: RTL and testbench
====================================

// Module: friscv_inst_queue
//
// PURPOSE
// Instruction queue between the central controller and the processing stage.
// - Buffers decoded instruction-bus words so the controller can keep issuing
//   while ALU, memfy or M-ext stall on hazards or backpressure.
// - Keeps issue order, reports occupancy and busy to the controller.
// - Supports a single-cycle flush, used on traps and branch redirects.
//
// PARAMETERS
// INST_BUS_W   `INST_BUS_W  width of one instruction-bus word
// DEPTH        4            entries; power of two, >= 2
// CNT_W        $clog2(DEPTH)+1  occupancy counter width (derived, do not override)
//
// PORTS
// aclk         in   1           clock
// aresetn      in   1           synchronous active-low reset
// flush        in   1           drop all entries; synchronous, 1-cycle pulse or level
// i_valid      in   1           controller has an instruction
// i_ready      out  1           queue accepts i_instbus
// i_instbus    in   INST_BUS_W  instruction bus from controller
// o_valid      out  1           instruction available to processing
// o_ready      in   1           processing accepts o_instbus
// o_instbus    out  INST_BUS_W  head instruction
// o_count      out  CNT_W       current occupancy, 0..DEPTH
// o_max_level  out  CNT_W       high-water mark of o_count since reset
// o_busy       out  1           o_count!=0 | i_valid
//
// BEHAVIOUR
// - Reset (aresetn=0 at posedge): wr/rd pointers, o_count, o_max_level -> 0.
//   o_valid=0 and i_ready=0 while aresetn=0. Storage contents are not reset.
//   Reset mid-operation discards all entries. No handshake completes in the reset cycle.
// - Push = i_valid & i_ready. Pop = o_valid & o_ready.
// - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   empty: ptrs equal; full: low bits equal, MSB differs.
// - i_ready = aresetn & !full & !flush. It does not depend on o_ready,
//   so a push is refused when full even if a pop occurs in the same cycle.
// - o_valid = !empty & !flush. o_instbus = mem[rd_ptr].
//   Both are held stable while o_valid & !o_ready.
// - Latency, storage path: a word pushed at edge N is presented with o_valid=1
//   after edge N. Sustained throughput is 1 word/cycle with push and pop together.
// - o_count updates per edge: +1 push only, -1 pop only, unchanged if both or neither.
// - o_max_level <= max(o_max_level, next o_count). It only resets on aresetn.
// - flush=1 at a posedge clears both pointers and o_count to 0.
//   Flush beats a simultaneous push or pop; neither handshake completes because
//   i_ready=o_valid=0. o_max_level is kept.
// - Ordering: strict FIFO; no reordering, no duplication.
//
// CONFIGURATION
// FRISCV_INSTQ_BYPASS_EN defined:
// - When the queue is empty and not flushing: o_valid=i_valid, o_instbus=i_instbus
//   (combinational path).
// - If o_ready=1 in that cycle, the word is consumed directly. It is not written,
//   and o_count stays 0.
// - If o_ready=0, the word is stored normally: i_ready=1, it becomes the head.
// FRISCV_INSTQ_BYPASS_EN undefined: every word goes through storage, with the
// 1-cycle minimum latency and no combinational i_* to o_* path.
//
// TESTING (DEPTH=4)
// - Fill: push A0..A3 with o_ready=0 -> i_ready=0 after 4th push, o_count=4,
//   o_max_level=4; then o_ready=1 -> A0,A1,A2,A3 out on 4 consecutive cycles.
// - Wrap/stream: 10 words, i_valid=o_ready=1 continuously -> all 10 out in order,
//   1/cycle after the first, o_count steady at 1 (0 with BYPASS_EN).
// - Backpressure: o_valid=1, o_ready held 0 for 5 cycles -> o_instbus unchanged,
//   o_count unchanged when no push.
// - Flush: o_count=3, flush=1 with i_valid=1 -> next cycle o_count=0, o_valid=0,
//   i_ready=1; the flushed push never appears; o_max_level stays 3.
// - Bypass: empty, i_valid=1, o_ready=1 -> with macro o_valid=1 in the same cycle
//   and o_count=0; without macro o_valid=1 one cycle later.
// - Reset mid-run: o_count=2, aresetn=0 for 1 cycle -> o_valid=0, o_count=0,
//   o_max_level=0; the next push is output first.

Source files
------------

// File: rtl/friscv_inst_queue.sv
// Instruction queue between the central controller and the processing stage.
// Optional combinational bypass when empty: define FRISCV_INSTQ_BYPASS_EN.

`ifndef INST_BUS_W
`define INST_BUS_W 32
`endif

module friscv_inst_queue #(
    parameter int INST_BUS_W = `INST_BUS_W,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [INST_BUS_W-1:0] i_instbus,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [INST_BUS_W-1:0] o_instbus,
    output logic [CNT_W-1:0]      o_count,
    output logic [CNT_W-1:0]      o_max_level,
    output logic                  o_busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [INST_BUS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, max_level, count_next;
    logic                  empty, full, bypass;
    logic                  push, pop, wr_en, rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

`ifdef FRISCV_INSTQ_BYPASS_EN
    assign bypass = aresetn & empty & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign i_ready   = aresetn & ~full & ~flush;
    assign o_valid   = bypass ? i_valid : (aresetn & ~empty & ~flush);
    assign o_instbus = bypass ? i_instbus : mem[rd_ptr[AW-1:0]];

    assign push  = i_valid & i_ready;
    assign pop   = o_valid & o_ready;
    // A bypassed word consumed in the same cycle never touches storage.
    assign wr_en = push & ~(bypass & o_ready);
    assign rd_en = pop & ~bypass;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (wr_en && !rd_en) begin
            count_next = count + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_level <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (count_next > max_level) max_level <= count_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= i_instbus;
    end

    assign o_count     = count;
    assign o_max_level = max_level;
    assign o_busy      = (count != '0) | i_valid;

endmodule

// File: tb/tb_friscv_inst_queue.sv
// Self-checking bench for friscv_inst_queue: directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.

module tb_friscv_inst_queue;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [W-1:0]  i_instbus = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [W-1:0]  o_instbus;
    logic [CW-1:0] o_count;
    logic [CW-1:0] o_max_level;
    logic          o_busy;

    friscv_inst_queue #(.INST_BUS_W(W), .DEPTH(D)) dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_instbus(i_instbus),
        .o_valid(o_valid), .o_ready(o_ready), .o_instbus(o_instbus),
        .o_count(o_count), .o_max_level(o_max_level), .o_busy(o_busy)
    );

    always #5 aclk = ~aclk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] q[$];
    int           max_lv = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        i_valid   = v;
        i_instbus = d;
        o_ready   = r;
        flush     = f;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit           byp, exp_rdy, exp_vld, push, pop;
        logic [W-1:0] exp_d;
        @(negedge aclk);
        byp = 1'b0;
`ifdef FRISCV_INSTQ_BYPASS_EN
        byp = aresetn && (q.size() == 0) && !flush;
`endif
        exp_rdy = aresetn && (q.size() < D) && !flush;
        exp_vld = byp ? i_valid : (aresetn && (q.size() > 0) && !flush);
        exp_d   = byp ? i_instbus : ((q.size() > 0) ? q[0] : '0);
        chk("i_ready", 64'(i_ready), 64'(exp_rdy));
        chk("o_valid", 64'(o_valid), 64'(exp_vld));
        if (exp_vld) chk("o_instbus", 64'(o_instbus), 64'(exp_d));
        chk("o_count", 64'(o_count), 64'(q.size()));
        chk("o_max_level", 64'(o_max_level), 64'(max_lv));
        chk("o_busy", 64'(o_busy), 64'((q.size() != 0) || i_valid));
        push = i_valid && exp_rdy;
        pop  = exp_vld && o_ready;
        @(posedge aclk);
        if (!aresetn) begin
            q.delete();
            max_lv = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop && !byp) void'(q.pop_front());
            if (push && !(byp && pop)) q.push_back(i_instbus);
        end
        if (q.size() > max_lv) max_lv = q.size();
        #1;
    endtask

    initial begin
        // reset
        aresetn = 1'b0;
        drive(1, 32'hDEAD0000, 1, 0);
        step(); step();
        aresetn = 1'b1;
        drive(0, '0, 0, 0);
        step();

        // flush with three held entries and a concurrent push
        for (int i = 0; i < 3; i++) begin drive(1, 32'hF000 + i, 0, 0); step(); end
        chk("pre_flush_count", 64'(o_count), 64'd3);
        drive(1, 32'hF0FF, 0, 1); step();
        drive(0, '0, 0, 0);
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_max", 64'(o_max_level), 64'd3);
        step();

        // fill to full, attempt an extra push, then drain
        for (int i = 0; i < 4; i++) begin drive(1, 32'hA000 + i, 0, 0); step(); end
        chk("full_count", 64'(o_count), 64'd4);
        chk("full_max", 64'(o_max_level), 64'd4);
        drive(1, 32'hA0FF, 1, 0); step();
        for (int i = 0; i < 5; i++) begin drive(0, '0, 1, 0); step(); end

        // streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin drive(1, 32'hB000 + i, 1, 0); step(); end
        drive(0, '0, 1, 0); step(); step();

        // backpressure: one entry held for five cycles
        drive(1, 32'hC001, 0, 0); step();
        for (int i = 0; i < 5; i++) begin drive(0, '0, 0, 0); step(); end
        drive(0, '0, 1, 0); step(); step();

        // empty with i_valid & o_ready together
        drive(1, 32'hE001, 1, 0); step();
        drive(0, '0, 1, 0); step();

        // reset mid-run with two entries
        for (int i = 0; i < 2; i++) begin drive(1, 32'h5000 + i, 0, 0); step(); end
        chk("pre_rst_count", 64'(o_count), 64'd2);
        aresetn = 1'b0;
        drive(1, 32'h50FF, 1, 0); step();
        aresetn = 1'b1;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_max", 64'(o_max_level), 64'd0);
        drive(1, 32'h6001, 0, 0); step();
        drive(0, '0, 1, 0); step(); step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            step();
        end
        drive(0, '0, 1, 0);
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
